alu_pipe: RTL
=============

# alu_pipe

Parametrised, pipelined successor of the 8-bit ALU. Width and timeout are parameters; it has a valid/ready output handshake with backpressure; and split operand delivery goes through a collector with a timeout. It sits between the operand/command sequencer and the result consumer. Results emerge in order, two clocks after the completing operand beat.

## Interface
Parameters:
- DW, 8: operand width (≥4, power of two)
- CW, 4: command width
- TIMEOUT, 16: maximum idle cycles between split operand beats

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; 0 freezes all state
- MODE  in  1  1 = arithmetic, 0 = logical
- CMD  in  CW  operation code
- INP_VALID  in  2  [0] = OPA valid, [1] = OPB valid
- OPA, OPB  in  DW  operands
- CIN  in  1  carry/borrow in
- IN_READY  out  1  beat on INP_VALID accepted this cycle
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- RES  out  2*DW  result, zero-extended
- COUT, OFLOW, G, E, L, ERR  out  1  flags

## Operation
- Collector FSM:
  - IDLE: 11 → ISSUE; 01 → HAVE_A; 10 → HAVE_B.
  - HAVE_A: 10 or 11 → ISSUE; 01 overwrites A and clears the counter.
  - HAVE_B: symmetric to HAVE_A.
  - ISSUE → IDLE after handoff to stage 1.
- MODE, CMD and CIN are captured on the completing beat.
- Timeout counter runs only in HAVE_A/HAVE_B on INP_VALID=00 cycles and saturates at TIMEOUT.
  - On reaching TIMEOUT, the collector issues an error transaction (RES=0, ERR=1, other flags 0), discards the held operand and returns to IDLE.
- Arithmetic (MODE=1):
  - 0 A+B; 1 A−B; 2 A+B+CIN; 3 A−B−CIN
  - 4 A+1; 5 A−1; 6 B+1; 7 B−1
  - 8 compare (RES=0)
  - 9 (A+1)*(B+1); 10 (A<<1)*B
- Arithmetic flags:
  - COUT = bit DW of the sum for 0, 2, 4, 6.
  - OFLOW = borrow for 1, 3, 5, 7.
  - G/E/L are one-hot for CMD 8 only, else 0.
- Logical (MODE=0):
  - 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR
  - 6 ~A; 7 ~B
  - 8 A>>1; 9 A<<1; 10 B>>1; 11 B<<1
  - 12 rotate A left by B[$clog2(DW)-1:0]; 13 rotate A right by the same amount
  - For 12/13, ERR=1 if any higher bit of B is set; RES is still computed.
- Unused CMD codes: RES=0, ERR=1.
- Outputs never drive X/Z.

## Timing
- Reset (async assert, sync deassert):
  - All outputs 0, except IN_READY, which is 0 during reset and 1 from the first edge after release.
  - FSM returns to IDLE, counter cleared, pipeline emptied.
- Latency:
  - Completing beat sampled at edge N → stage 1 at N, RES/flags registered at N+1.
  - OUT_VALID is high from N+1.
- Throughput: one transaction per clock without backpressure.
- Backpressure:
  - While OUT_VALID && !OUT_READY, RES/flags hold stable and stage 2 stalls.
  - A full stage 1 stalls when stage 2 stalls.
  - IN_READY = CE && !(s1_full && s2_stall).
  - Beats presented with IN_READY=0 are ignored; the sender holds them.
- Handshake transfer occurs on OUT_VALID && OUT_READY. A new result may load in the same edge.
- CE=0: no state change, counter frozen, IN_READY=0; OUT_VALID/RES held.
- Reset mid-operation discards collector contents and in-flight results. No partial result ever appears.
- A timeout and a completing beat in the same cycle: the completing beat wins and a normal result is issued.

## Configuration
- ALU_PIPE_MUL_EN
  - Defined: arithmetic CMD 9/10 use a DW×DW multiplier split across the two stages.
  - Undefined: CMD 9/10 are treated as unused codes (RES=0, ERR=1), and no multiplier is synthesised.

## Structure
- Package alu_pipe_pkg:
  - Arithmetic and logical command enums
  - Collector state enum (IDLE, HAVE_A, HAVE_B, ISSUE)
  - Packed result struct (res, cout, oflow, g, e, l, err)
  - Default TIMEOUT constant
- Sub-module alu_pipe_collector: operand capture FSM, timeout counter and error-transaction issue.
- Top level: compute stages and handshake.

## Test plan
- Reset mid-flight: OPA=3, OPB=4, 11, CMD=0, then RST_N low before N+1 → OUT_VALID never rises; all outputs 0.
- MODE=1, CMD=0, OPA=200, OPB=100, INP_VALID=11 → two edges later RES=300, COUT=1, OUT_VALID=1.
- MODE=1, CMD=9 (MUL_EN), OPA=15 via 01, 5 idle cycles, OPB=15 via 10 → RES=256, ERR=0.
- OPA via 01, then 16 cycles of 00 → one result with ERR=1, RES=0; a subsequent 10 starts in HAVE_B.
- OUT_READY=0, three back-to-back 11 beats → IN_READY drops after the second beat; after release, results arrive in order, one per clock.
- MODE=0, CMD=12, OPA=0x81, OPB=0x01 → RES=0x03, ERR=0; OPB=0x11 → RES=0x03, ERR=1.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared command codes, collector states and flag struct for alu_pipe
package alu_pipe_pkg;

   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [3:0] {
      A_ADD  = 4'd0,
      A_SUB  = 4'd1,
      A_ADDC = 4'd2,
      A_SUBC = 4'd3,
      A_INCA = 4'd4,
      A_DECA = 4'd5,
      A_INCB = 4'd6,
      A_DECB = 4'd7,
      A_CMP  = 4'd8,
      A_MULI = 4'd9,
      A_MULS = 4'd10
   } arith_cmd_e;

   typedef enum logic [3:0] {
      L_AND  = 4'd0,
      L_NAND = 4'd1,
      L_OR   = 4'd2,
      L_NOR  = 4'd3,
      L_XOR  = 4'd4,
      L_XNOR = 4'd5,
      L_NOTA = 4'd6,
      L_NOTB = 4'd7,
      L_SHRA = 4'd8,
      L_SHLA = 4'd9,
      L_SHRB = 4'd10,
      L_SHLB = 4'd11,
      L_ROLA = 4'd12,
      L_RORA = 4'd13
   } logic_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HAVE_A = 2'd1,
      ST_HAVE_B = 2'd2,
      ST_ISSUE  = 2'd3
   } coll_state_e;

   // Result width depends on the instance DW, so the top pairs this with its own res field.
   typedef struct packed {
      logic cout;
      logic oflow;
      logic g;
      logic e;
      logic l;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_pipe_collector.sv
// rtl/alu_pipe_collector.sv - split-operand collector with idle timeout and error issue
// The completing beat is handed to stage 1 combinationally so it loads on the same edge.
module alu_pipe_collector
   import alu_pipe_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce,
   input  logic          ready,
   input  logic [1:0]    inp_valid,
   input  logic [DW-1:0] opa,
   input  logic [DW-1:0] opb,
   output logic          iss_valid,
   output logic [DW-1:0] iss_a,
   output logic [DW-1:0] iss_b,
   output logic          iss_tout
);
   localparam int             CNTW    = $clog2(TIMEOUT + 1);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

   coll_state_e   state_q, state_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      iss_valid = 1'b0;
      iss_a     = opa;
      iss_b     = opb;
      iss_tout  = 1'b0;
      if (ce) begin
         case (state_q)
            // ISSUE only marks a handoff that already happened; it decodes beats like IDLE.
            ST_IDLE, ST_ISSUE: begin
               state_d = ST_IDLE;
               if (ready) begin
                  case (inp_valid)
                     2'b11: begin
                        iss_valid = 1'b1;
                        state_d   = ST_ISSUE;
                     end
                     2'b01: begin
                        a_d     = opa;
                        cnt_d   = '0;
                        state_d = ST_HAVE_A;
                     end
                     2'b10: begin
                        b_d     = opb;
                        cnt_d   = '0;
                        state_d = ST_HAVE_B;
                     end
                     default: ;
                  endcase
               end
            end
            ST_HAVE_A: begin
               iss_a = inp_valid[0] ? opa : a_q;
               if (inp_valid == 2'b00) begin
                  if (cnt_q == CNT_MAX) begin
                     if (ready) begin
                        iss_valid = 1'b1;
                        iss_tout  = 1'b1;
                        a_d       = '0;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (ready) begin
                  cnt_d = '0;
                  if (inp_valid[1]) begin
                     iss_valid = 1'b1;
                     state_d   = ST_ISSUE;
                  end else begin
                     a_d = opa;
                  end
               end
            end
            ST_HAVE_B: begin
               iss_b = inp_valid[1] ? opb : b_q;
               if (inp_valid == 2'b00) begin
                  if (cnt_q == CNT_MAX) begin
                     if (ready) begin
                        iss_valid = 1'b1;
                        iss_tout  = 1'b1;
                        b_d       = '0;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (ready) begin
                  cnt_d = '0;
                  if (inp_valid[0]) begin
                     iss_valid = 1'b1;
                     state_d   = ST_ISSUE;
                  end else begin
                     b_d = opb;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with operand collector and valid/ready output
// Define ALU_PIPE_MUL_EN to enable arithmetic CMD 9/10 (multiplier split across both stages).
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int DW      = 8,
   parameter int CW      = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            CE,
   input  logic            MODE,
   input  logic [CW-1:0]   CMD,
   input  logic [1:0]      INP_VALID,
   input  logic [DW-1:0]   OPA,
   input  logic [DW-1:0]   OPB,
   input  logic            CIN,
   output logic            IN_READY,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [2*DW-1:0] RES,
   output logic            COUT,
   output logic            OFLOW,
   output logic            G,
   output logic            E,
   output logic            L,
   output logic            ERR
);
   localparam int RW = 2 * DW;
   localparam int LW = $clog2(DW);

   logic          rdy_q, rdy_d;
   logic          s1_full_q, s1_full_d;
   logic          s1_mode_q, s1_mode_d;
   logic [CW-1:0] s1_cmd_q, s1_cmd_d;
   logic          s1_cin_q, s1_cin_d;
   logic [DW-1:0] s1_a_q, s1_a_d;
   logic [DW-1:0] s1_b_q, s1_b_d;
   logic          s1_tout_q, s1_tout_d;
`ifdef ALU_PIPE_MUL_EN
   logic [DW-1:0] s1_ma_q, s1_ma_d;
   logic [DW-1:0] s1_mb_q, s1_mb_d;
`endif
   logic          s2_valid_q, s2_valid_d;
   logic [RW-1:0] s2_res_q, s2_res_d;
   alu_flags_t    s2_flg_q, s2_flg_d;

   logic          iss_valid, iss_tout;
   logic [DW-1:0] iss_a, iss_b;
   logic          s2_stall, s2_take;
   logic [RW-1:0] c_res;
   alu_flags_t    c_flg;

   assign s2_stall = s2_valid_q && !OUT_READY;
   assign s2_take  = CE && s1_full_q && !s2_stall;
   // rdy_q keeps IN_READY low until the first edge after reset release.
   assign IN_READY = rdy_q && CE && !(s1_full_q && s2_stall);

   alu_pipe_collector #(
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) u_collector (
      .clk       (CLK),
      .rst_n     (RST_N),
      .ce        (CE),
      .ready     (IN_READY),
      .inp_valid (INP_VALID),
      .opa       (OPA),
      .opb       (OPB),
      .iss_valid (iss_valid),
      .iss_a     (iss_a),
      .iss_b     (iss_b),
      .iss_tout  (iss_tout)
   );

   always_comb begin
      logic [DW:0]   ax;
      logic [DW:0]   bx;
      logic [DW:0]   sum;
      logic [DW-1:0] lres;
      logic [RW-1:0] rot;
      logic [3:0]    op;
      ax    = {1'b0, s1_a_q};
      bx    = {1'b0, s1_b_q};
      sum   = '0;
      lres  = '0;
      rot   = '0;
      op    = s1_cmd_q[3:0];
      c_res = '0;
      c_flg = '0;
      if (s1_tout_q || ((s1_cmd_q >> 4) != '0)) begin
         c_flg.err = 1'b1;
      end else if (s1_mode_q) begin
         case (op)
            A_ADD:  begin sum = ax + bx;                     c_res = RW'(sum);          c_flg.cout  = sum[DW]; end
            A_SUB:  begin sum = ax - bx;                     c_res = RW'(sum[DW-1:0]);  c_flg.oflow = sum[DW]; end
            A_ADDC: begin sum = ax + bx + {{DW{1'b0}}, s1_cin_q}; c_res = RW'(sum);     c_flg.cout  = sum[DW]; end
            A_SUBC: begin sum = ax - bx - {{DW{1'b0}}, s1_cin_q}; c_res = RW'(sum[DW-1:0]); c_flg.oflow = sum[DW]; end
            A_INCA: begin sum = ax + 1'b1;                   c_res = RW'(sum);          c_flg.cout  = sum[DW]; end
            A_DECA: begin sum = ax - 1'b1;                   c_res = RW'(sum[DW-1:0]);  c_flg.oflow = sum[DW]; end
            A_INCB: begin sum = bx + 1'b1;                   c_res = RW'(sum);          c_flg.cout  = sum[DW]; end
            A_DECB: begin sum = bx - 1'b1;                   c_res = RW'(sum[DW-1:0]);  c_flg.oflow = sum[DW]; end
            A_CMP: begin
               c_flg.g = s1_a_q > s1_b_q;
               c_flg.e = s1_a_q == s1_b_q;
               c_flg.l = s1_a_q < s1_b_q;
            end
`ifdef ALU_PIPE_MUL_EN
            A_MULI, A_MULS: c_res = {{DW{1'b0}}, s1_ma_q} * {{DW{1'b0}}, s1_mb_q};
`endif
            default: c_flg.err = 1'b1;
         endcase
      end else begin
         case (op)
            L_AND:  lres = s1_a_q & s1_b_q;
            L_NAND: lres = ~(s1_a_q & s1_b_q);
            L_OR:   lres = s1_a_q | s1_b_q;
            L_NOR:  lres = ~(s1_a_q | s1_b_q);
            L_XOR:  lres = s1_a_q ^ s1_b_q;
            L_XNOR: lres = ~(s1_a_q ^ s1_b_q);
            L_NOTA: lres = ~s1_a_q;
            L_NOTB: lres = ~s1_b_q;
            L_SHRA: lres = s1_a_q >> 1;
            L_SHLA: lres = s1_a_q << 1;
            L_SHRB: lres = s1_b_q >> 1;
            L_SHLB: lres = s1_b_q << 1;
            // Rotates shift a doubled copy of A; the result is still produced when B is out of range.
            L_ROLA: begin
               rot       = {s1_a_q, s1_a_q} << s1_b_q[LW-1:0];
               lres      = rot[RW-1:DW];
               c_flg.err = (s1_b_q >> LW) != '0;
            end
            L_RORA: begin
               rot       = {s1_a_q, s1_a_q} >> s1_b_q[LW-1:0];
               lres      = rot[DW-1:0];
               c_flg.err = (s1_b_q >> LW) != '0;
            end
            default: c_flg.err = 1'b1;
         endcase
         c_res = RW'(lres);
      end
   end

   always_comb begin
      rdy_d      = 1'b1;
      s1_full_d  = s1_full_q;
      s1_mode_d  = s1_mode_q;
      s1_cmd_d   = s1_cmd_q;
      s1_cin_d   = s1_cin_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_tout_d  = s1_tout_q;
`ifdef ALU_PIPE_MUL_EN
      s1_ma_d    = s1_ma_q;
      s1_mb_d    = s1_mb_q;
`endif
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_flg_d   = s2_flg_q;
      if (CE) begin
         if (s2_take) begin
            s2_valid_d = 1'b1;
            s2_res_d   = c_res;
            s2_flg_d   = c_flg;
         end else if (OUT_READY) begin
            s2_valid_d = 1'b0;
         end
         if (iss_valid) begin
            s1_full_d = 1'b1;
            s1_mode_d = MODE;
            s1_cmd_d  = CMD;
            s1_cin_d  = CIN;
            s1_a_d    = iss_a;
            s1_b_d    = iss_b;
            s1_tout_d = iss_tout;
`ifdef ALU_PIPE_MUL_EN
            // Multiplier operands are prepared here so stage 2 only multiplies.
            s1_ma_d = (CMD[3:0] == A_MULI) ? iss_a + 1'b1 : iss_a << 1;
            s1_mb_d = (CMD[3:0] == A_MULI) ? iss_b + 1'b1 : iss_b;
`endif
         end else if (s2_take) begin
            s1_full_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdy_q      <= 1'b0;
         s1_full_q  <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_cmd_q   <= '0;
         s1_cin_q   <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_tout_q  <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         s1_ma_q    <= '0;
         s1_mb_q    <= '0;
`endif
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_flg_q   <= '0;
      end else begin
         rdy_q      <= rdy_d;
         s1_full_q  <= s1_full_d;
         s1_mode_q  <= s1_mode_d;
         s1_cmd_q   <= s1_cmd_d;
         s1_cin_q   <= s1_cin_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_tout_q  <= s1_tout_d;
`ifdef ALU_PIPE_MUL_EN
         s1_ma_q    <= s1_ma_d;
         s1_mb_q    <= s1_mb_d;
`endif
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_flg_q   <= s2_flg_d;
      end
   end

   assign OUT_VALID = s2_valid_q;
   assign RES       = s2_res_q;
   assign COUT      = s2_flg_q.cout;
   assign OFLOW     = s2_flg_q.oflow;
   assign G         = s2_flg_q.g;
   assign E         = s2_flg_q.e;
   assign L         = s2_flg_q.l;
   assign ERR       = s2_flg_q.err;

endmodule
